pc_flags_unit: RTL

//  Program-counter and processor-status block beside the multicycle controller.

---
 rtl/pc_flags_unit_pkg.sv | 36 +++
 rtl/pc_flags_unit_if.sv | 30 +++
 rtl/pc_flags_unit_cond_eval.sv | 40 ++++
 rtl/pc_flags_unit.sv | 57 +++++
 4 files changed

// File: rtl/pc_flags_unit_pkg.sv
// Shared encodings for the PC command, the condition field and the status-flag layout.
// The multicycle controller imports the same PC command constants.
package pc_flags_unit_pkg;

  localparam logic [1:0] PcenHold = 2'b00;
  localparam logic [1:0] PcenRst  = 2'b01;
  localparam logic [1:0] PcenJmp  = 2'b10;
  localparam logic [1:0] PcenStep = 2'b11;

  // Bit positions inside the {C,L,F,Z,N} flag vector.
  localparam int unsigned FlagC = 4;
  localparam int unsigned FlagL = 3;
  localparam int unsigned FlagF = 2;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagN = 0;

  localparam int unsigned FlagsW = 5;

  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondHi = 4'b0100;
  localparam logic [3:0] CondLs = 4'b0101;
  localparam logic [3:0] CondGt = 4'b0110;
  localparam logic [3:0] CondLe = 4'b0111;
  localparam logic [3:0] CondFs = 4'b1000;
  localparam logic [3:0] CondFc = 4'b1001;
  localparam logic [3:0] CondLo = 4'b1010;
  localparam logic [3:0] CondHs = 4'b1011;
  localparam logic [3:0] CondLt = 4'b1100;
  localparam logic [3:0] CondGe = 4'b1101;
  localparam logic [3:0] CondUc = 4'b1110;
  localparam logic [3:0] CondNv = 4'b1111;

endpackage

// File: rtl/pc_flags_unit_if.sv
// Command/status bundle between the multicycle controller (master) and the PC/flags unit.
interface pc_flags_unit_if #(
  parameter int unsigned Width = 16,
  parameter int unsigned DispW = 8
);
  import pc_flags_unit_pkg::*;

  logic [1:0]        pc_en;
  logic              mux_pc;
  logic [Width-1:0]  target;
  logic [DispW-1:0]  disp;
  logic              codes_computed;
  logic [FlagsW-1:0] alu_flags;
  logic [3:0]        cond_sel;

  logic [Width-1:0]  pc;
  logic [Width-1:0]  pc_plus1;
  logic [FlagsW-1:0] flags;
  logic [Width-1:0]  con_codes_out;

  modport master (
    output pc_en, mux_pc, target, disp, codes_computed, alu_flags, cond_sel,
    input  pc, pc_plus1, flags, con_codes_out
  );

  modport slave (
    input  pc_en, mux_pc, target, disp, codes_computed, alu_flags, cond_sel,
    output pc, pc_plus1, flags, con_codes_out
  );
endinterface

// File: rtl/pc_flags_unit_cond_eval.sv
// Purely combinational condition evaluator; also reused by the Scond write-back path.
module pc_flags_unit_cond_eval
  import pc_flags_unit_pkg::*;
(
  input  logic [FlagsW-1:0] flags_i,
  input  logic [3:0]        cond_sel_i,
  output logic              cond_true_o
);

  logic c, l, f, z, n;

  assign c = flags_i[FlagC];
  assign l = flags_i[FlagL];
  assign f = flags_i[FlagF];
  assign z = flags_i[FlagZ];
  assign n = flags_i[FlagN];

  always_comb begin
    cond_true_o = 1'b0;
    unique case (cond_sel_i)
      CondEq: cond_true_o = z;
      CondNe: cond_true_o = ~z;
      CondCs: cond_true_o = c;
      CondCc: cond_true_o = ~c;
      CondHi: cond_true_o = l;
      CondLs: cond_true_o = ~l;
      CondGt: cond_true_o = n;
      CondLe: cond_true_o = ~n;
      CondFs: cond_true_o = f;
      CondFc: cond_true_o = ~f;
      CondLo: cond_true_o = ~l & ~z;
      CondHs: cond_true_o = l | z;
      CondLt: cond_true_o = ~n & ~z;
      CondGe: cond_true_o = n | z;
      CondUc: cond_true_o = 1'b1;
      CondNv: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flags_unit.sv
// PC register with next-PC mux, status-flag register and condition-code output.
module pc_flags_unit
  import pc_flags_unit_pkg::*;
#(
  parameter int unsigned     Width    = 16,
  parameter int unsigned     DispW    = 8,
  parameter logic [Width-1:0] ResetVec = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_flags_unit_if.slave  ctrl_io
);

  logic [Width-1:0]  pc_q, pc_d;
  logic [Width-1:0]  pc_plus1;
  logic [Width-1:0]  disp_sext;
  logic [FlagsW-1:0] flags_q, flags_d;
  logic              cond_true;

  assign pc_plus1  = pc_q + Width'(1);
  assign disp_sext = {{(Width - DispW){ctrl_io.disp[DispW-1]}}, ctrl_io.disp};

  always_comb begin
    pc_d = pc_q;
    unique case (ctrl_io.pc_en)
      PcenHold: pc_d = pc_q;
      PcenRst:  pc_d = ResetVec;
      PcenJmp:  pc_d = ctrl_io.mux_pc ? ctrl_io.target : pc_plus1;
      PcenStep: pc_d = ctrl_io.mux_pc ? (pc_q + disp_sext) : pc_plus1;
    endcase
  end

  assign flags_d = ctrl_io.codes_computed ? ctrl_io.alu_flags : flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= ResetVec;
      flags_q <= '0;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  // Evaluated from the registered flags, so a branch never sees flags captured on its own edge.
  pc_flags_unit_cond_eval u_cond_eval (
    .flags_i     (flags_q),
    .cond_sel_i  (ctrl_io.cond_sel),
    .cond_true_o (cond_true)
  );

  assign ctrl_io.pc            = pc_q;
  assign ctrl_io.pc_plus1      = pc_plus1;
  assign ctrl_io.flags         = flags_q;
  assign ctrl_io.con_codes_out = {{(Width - FlagsW - 1){1'b0}}, flags_q, cond_true};

endmodule
